// File: rtl/mem_access_stage.sv
// mem_access_stage
//
// Memory stage directly downstream of the ALU. Each accepted execute
// result takes one of three paths:
//   - non-memory op: the ALU result is passed to writeback one cycle later
//   - LW/SW with a misaligned word address: an exception entry is produced
//     one cycle later and no bus request is issued
//   - aligned LW/SW: a request is issued on the data bus and the stage
//     stalls upstream until the bus reports data_ok
// The writeback entry is a single registered slot; out_valid pulses for
// exactly one cycle per completed instruction, and the payload fields hold
// their last value in between pulses.
//
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   in_valid/in_ready   execute-result handshake (in_ready high only in IDLE)
//   in_op               ALU op code, compared against F6_LW / F6_SW
//   in_result           ALU result: word address for LW/SW, data otherwise
//   in_store_data       rt value written by SW
//   in_dst, in_wen      destination register and its write enable
//   dreq_*              data bus request (valid/addr/strobe/data)
//   dresp_data_ok       bus completed the outstanding request
//   dresp_data          load data, valid together with dresp_data_ok
//   out_valid           one-cycle writeback pulse
//   out_data/dst/wen    writeback payload
//   out_exc             address-misaligned exception flag

package mem_stage_pkg;
  localparam logic [5:0] F6_ADD = 6'h20;
  localparam logic [5:0] F6_LW  = 6'h23;
  localparam logic [5:0] F6_SW  = 6'h2B;
endpackage

module mem_access_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              in_valid,
  output logic              in_ready,
  input  logic [5:0]        in_op,
  input  logic [31:0]       in_result,
  input  logic [31:0]       in_store_data,
  input  logic [4:0]        in_dst,
  input  logic              in_wen,

  output logic              dreq_valid,
  output logic [ADDR_W-1:0] dreq_addr,
  output logic [3:0]        dreq_strobe,
  output logic [31:0]       dreq_data,
  input  logic              dresp_data_ok,
  input  logic [31:0]       dresp_data,

  output logic              out_valid,
  output logic [31:0]       out_data,
  output logic [4:0]        out_dst,
  output logic              out_wen,
  output logic              out_exc
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t state;
  state_t state_n;

  // Decode of the incoming execute result
  logic is_load;
  logic is_store;
  logic is_mem;
  logic misaligned;

  // One-hot actions chosen for the coming edge
  logic take_pass;
  logic take_exc;
  logic start_req;
  logic finish_req;

  // Context of the outstanding bus transaction
  logic [4:0] pend_dst;
  logic       pend_wen;
  logic       pend_load;

  assign is_load    = (in_op == F6_LW);
  assign is_store   = (in_op == F6_SW);
  assign is_mem     = is_load || is_store;
  assign misaligned = (in_result[1:0] != 2'b00);

  assign in_ready   = (state == IDLE);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next state and action select. dresp_data_ok is only looked at in WAIT,
  // so a stray data_ok while IDLE has no effect.
  always_comb begin
    state_n    = state;
    take_pass  = 1'b0;
    take_exc   = 1'b0;
    start_req  = 1'b0;
    finish_req = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          if (!is_mem) begin
            take_pass = 1'b1;
          end else if (misaligned) begin
            take_exc = 1'b1;
          end else begin
            start_req = 1'b1;
            state_n   = WAIT;
          end
        end
      end
      WAIT: begin
        if (dresp_data_ok) begin
          finish_req = 1'b1;
          state_n    = IDLE;
        end
      end
    endcase
  end

  // Bus request registers: loaded on issue and held untouched while
  // waiting, so addr/strobe/data stay stable for the whole transaction.
  always_ff @(posedge clk) begin
    if (reset) begin
      dreq_valid  <= 1'b0;
      dreq_addr   <= '0;
      dreq_strobe <= '0;
      dreq_data   <= '0;
      pend_dst    <= '0;
      pend_wen    <= 1'b0;
      pend_load   <= 1'b0;
    end else if (start_req) begin
      dreq_valid  <= 1'b1;
      dreq_addr   <= in_result[ADDR_W-1:0];
      dreq_strobe <= is_store ? 4'b1111 : 4'b0000;
      dreq_data   <= is_store ? in_store_data : '0;
      pend_dst    <= in_dst;
      pend_wen    <= in_wen;
      pend_load   <= is_load;
    end else if (finish_req) begin
      dreq_valid  <= 1'b0;
    end
  end

  // Writeback slot. out_valid defaults low each cycle; the payload is only
  // rewritten when a completion happens, so it holds between pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_dst   <= '0;
      out_wen   <= 1'b0;
      out_exc   <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (take_pass) begin
        out_valid <= 1'b1;
        out_data  <= in_result;
        out_dst   <= in_dst;
        out_wen   <= in_wen;
        out_exc   <= 1'b0;
      end else if (take_exc) begin
        // Faulting access reports the offending address and never writes
        out_valid <= 1'b1;
        out_data  <= in_result;
        out_dst   <= in_dst;
        out_wen   <= 1'b0;
        out_exc   <= 1'b1;
      end else if (finish_req) begin
        out_valid <= 1'b1;
        out_data  <= pend_load ? dresp_data : '0;
        out_dst   <= pend_dst;
        out_wen   <= pend_load ? pend_wen : 1'b0;
        out_exc   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
module tb_mem_access_stage;
  import mem_stage_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  in_op;
  logic [31:0] in_result;
  logic [31:0] in_store_data;
  logic [4:0]  in_dst;
  logic        in_wen;
  logic        dreq_valid;
  logic [31:0] dreq_addr;
  logic [3:0]  dreq_strobe;
  logic [31:0] dreq_data;
  logic        dresp_data_ok;
  logic [31:0] dresp_data;
  logic        out_valid;
  logic [31:0] out_data;
  logic [4:0]  out_dst;
  logic        out_wen;
  logic        out_exc;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mem_access_stage #(.ADDR_W(32)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_result(in_result), .in_store_data(in_store_data),
    .in_dst(in_dst), .in_wen(in_wen),
    .dreq_valid(dreq_valid), .dreq_addr(dreq_addr),
    .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
    .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data),
    .out_valid(out_valid), .out_data(out_data), .out_dst(out_dst),
    .out_wen(out_wen), .out_exc(out_exc)
  );

  task automatic idle_inputs();
    in_valid = 1'b0; in_op = F6_ADD; in_result = '0; in_store_data = '0;
    in_dst = '0; in_wen = 1'b0; dresp_data_ok = 1'b0; dresp_data = '0;
  endtask

  task automatic drive_instr(input logic [5:0] op, input logic [31:0] res,
                             input logic [31:0] sd, input logic [4:0] dst,
                             input logic wen);
    in_valid = 1'b1; in_op = op; in_result = res; in_store_data = sd;
    in_dst = dst; in_wen = wen;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    drive_instr(F6_ADD, 32'hFFFF_FFFF, 32'h5555_5555, 5'd31, 1'b1);
    dresp_data_ok = 1'b1;
    repeat (2) @(negedge clk);
    tests++;
    if ({dreq_valid, dreq_addr, dreq_strobe, dreq_data} !== 69'd0) begin
      fails++; $display("FAIL reset_dreq: got v=%b a=%h s=%b d=%h want all zero",
                        dreq_valid, dreq_addr, dreq_strobe, dreq_data);
    end
    tests++;
    if ({out_valid, out_data, out_dst, out_wen, out_exc} !== 40'd0) begin
      fails++; $display("FAIL reset_out: got v=%b d=%h dst=%0d wen=%b exc=%b want all zero",
                        out_valid, out_data, out_dst, out_wen, out_exc);
    end
    tests++;
    if (in_ready !== 1'b1) begin
      fails++; $display("FAIL reset_ready: got %b want 1", in_ready);
    end
    reset = 1'b0;
    idle_inputs();
  endtask

  task automatic test_passthrough();
    @(negedge clk);
    drive_instr(F6_ADD, 32'h0000_0007, 32'h0, 5'd3, 1'b1);
    @(negedge clk);
    idle_inputs();
    tests++;
    if ({out_valid, out_data, out_dst, out_wen, out_exc} !== {1'b1, 32'd7, 5'd3, 1'b1, 1'b0}) begin
      fails++; $display("FAIL pass_out: got v=%b d=%h dst=%0d wen=%b exc=%b want 1/7/3/1/0",
                        out_valid, out_data, out_dst, out_wen, out_exc);
    end
    tests++;
    if (dreq_valid !== 1'b0) begin
      fails++; $display("FAIL pass_dreq: got %b want 0", dreq_valid);
    end
    @(negedge clk);
    tests++;
    if (out_valid !== 1'b0 || out_data !== 32'd7) begin
      fails++; $display("FAIL pass_pulse: got v=%b d=%h want 0 with data held 7", out_valid, out_data);
    end
  endtask

  task automatic test_load();
    @(negedge clk);
    drive_instr(F6_LW, 32'h0000_0100, 32'hAAAA_AAAA, 5'd8, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      idle_inputs();
      tests++;
      if ({dreq_valid, dreq_addr, dreq_strobe, in_ready, out_valid} !==
          {1'b1, 32'h100, 4'b0000, 1'b0, 1'b0}) begin
        fails++; $display("FAIL load_wait[%0d]: got v=%b a=%h s=%b rdy=%b ov=%b want 1/100/0000/0/0",
                          i, dreq_valid, dreq_addr, dreq_strobe, in_ready, out_valid);
      end
      tests++;
      if (dreq_data !== 32'd0) begin
        fails++; $display("FAIL load_dreq_data[%0d]: got %h want 0", i, dreq_data);
      end
      dresp_data_ok = (i == 3);
      dresp_data = (i == 3) ? 32'hDEAD_BEEF : 32'h0BAD_0BAD;
    end
    @(negedge clk);
    idle_inputs();
    tests++;
    if ({out_valid, out_data, out_dst, out_wen, out_exc} !== {1'b1, 32'hDEAD_BEEF, 5'd8, 1'b1, 1'b0}) begin
      fails++; $display("FAIL load_out: got v=%b d=%h dst=%0d wen=%b exc=%b want 1/deadbeef/8/1/0",
                        out_valid, out_data, out_dst, out_wen, out_exc);
    end
    tests++;
    if (dreq_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++; $display("FAIL load_release: got dreq_valid=%b in_ready=%b want 0/1", dreq_valid, in_ready);
    end
  endtask

  task automatic test_store();
    @(negedge clk);
    drive_instr(F6_SW, 32'h0000_0204, 32'h1234_5678, 5'd9, 1'b1);
    @(negedge clk);
    idle_inputs();
    tests++;
    if ({dreq_valid, dreq_addr, dreq_strobe, dreq_data} !== {1'b1, 32'h204, 4'b1111, 32'h1234_5678}) begin
      fails++; $display("FAIL store_req: got v=%b a=%h s=%b d=%h want 1/204/1111/12345678",
                        dreq_valid, dreq_addr, dreq_strobe, dreq_data);
    end
    dresp_data_ok = 1'b1;
    dresp_data = 32'hCAFE_F00D;
    @(negedge clk);
    idle_inputs();
    tests++;
    if ({out_valid, out_data, out_wen, out_exc} !== {1'b1, 32'd0, 1'b0, 1'b0}) begin
      fails++; $display("FAIL store_out: got v=%b d=%h wen=%b exc=%b want 1/0/0/0",
                        out_valid, out_data, out_wen, out_exc);
    end
  endtask

  task automatic test_misaligned();
    @(negedge clk);
    drive_instr(F6_LW, 32'h0000_0102, 32'h0, 5'd4, 1'b1);
    @(negedge clk);
    idle_inputs();
    tests++;
    if ({out_valid, out_data, out_dst, out_wen, out_exc} !== {1'b1, 32'h102, 5'd4, 1'b0, 1'b1}) begin
      fails++; $display("FAIL misaligned_out: got v=%b d=%h dst=%0d wen=%b exc=%b want 1/102/4/0/1",
                        out_valid, out_data, out_dst, out_wen, out_exc);
    end
    tests++;
    if (dreq_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++; $display("FAIL misaligned_bus: got dreq_valid=%b in_ready=%b want 0/1", dreq_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid_wait();
    @(negedge clk);
    drive_instr(F6_SW, 32'h0000_0300, 32'h7777_0000, 5'd2, 1'b0);
    @(negedge clk);
    idle_inputs();
    tests++;
    if (dreq_valid !== 1'b1) begin
      fails++; $display("FAIL rst_wait_issue: got dreq_valid=%b want 1", dreq_valid);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    tests++;
    if (dreq_valid !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
      fails++; $display("FAIL rst_wait_after: got dreq_valid=%b in_ready=%b out_valid=%b want 0/1/0",
                        dreq_valid, in_ready, out_valid);
    end
    dresp_data_ok = 1'b1;
    dresp_data = 32'h1111_2222;
    @(negedge clk);
    idle_inputs();
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || dreq_valid !== 1'b0) begin
      fails++; $display("FAIL rst_wait_stray: got out_valid=%b in_ready=%b dreq_valid=%b want 0/1/0",
                        out_valid, in_ready, dreq_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_d [6];
    logic        exp_v [6];
    logic        exp_r [6];
    exp_v = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    exp_d = '{32'h0, 32'h11, 32'h22, 32'h22, 32'h5A5A_0001, 32'h33};
    exp_r = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c > 0) begin
        tests++;
        if (out_valid !== exp_v[c] || (exp_v[c] && out_data !== exp_d[c])) begin
          fails++; $display("FAIL b2b_cycle%0d: got v=%b d=%h want v=%b d=%h",
                            c, out_valid, out_data, exp_v[c], exp_d[c]);
        end
        tests++;
        if (in_ready !== exp_r[c]) begin
          fails++; $display("FAIL b2b_ready%0d: got %b want %b", c, in_ready, exp_r[c]);
        end
      end
      idle_inputs();
      case (c)
        0: drive_instr(F6_ADD, 32'h11, 32'h0, 5'd1, 1'b1);
        1: drive_instr(F6_ADD, 32'h22, 32'h0, 5'd2, 1'b1);
        2: drive_instr(F6_LW, 32'h40, 32'h0, 5'd3, 1'b1);
        3: begin
          drive_instr(F6_ADD, 32'h33, 32'h0, 5'd4, 1'b1);
          dresp_data_ok = 1'b1;
          dresp_data = 32'h5A5A_0001;
        end
        4: drive_instr(F6_ADD, 32'h33, 32'h0, 5'd4, 1'b1);
        default: ;
      endcase
    end
    @(negedge clk);
    tests++;
    if (out_valid !== 1'b0) begin
      fails++; $display("FAIL b2b_tail: got out_valid=%b want 0", out_valid);
    end
  endtask

  // Random traffic against a transaction-level model: each accepted
  // instruction's outcome is computed from the op/address rules, and a bus
  // responder with random latency supplies load data.
  task automatic test_random();
    bit          busy = 0;
    int          wait_left = 0;
    logic [31:0] r_addr = '0, r_data = '0;
    logic [3:0]  r_strb = '0;
    logic        r_load = 0, r_wen = 0;
    logic [4:0]  r_dst = '0;
    bit          exp_v = 0;
    logic [31:0] exp_data = '0;
    logic [4:0]  exp_dst = '0;
    logic        exp_wen = 0, exp_exc = 0;
    logic [5:0]  op;
    logic [31:0] res;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      if (cyc > 0) begin
        tests++;
        if (out_valid !== exp_v || out_data !== exp_data || out_dst !== exp_dst ||
            out_wen !== exp_wen || out_exc !== exp_exc) begin
          fails++; $display("FAIL rand_out@%0d: got v=%b d=%h dst=%0d wen=%b exc=%b want v=%b d=%h dst=%0d wen=%b exc=%b",
                            cyc, out_valid, out_data, out_dst, out_wen, out_exc,
                            exp_v, exp_data, exp_dst, exp_wen, exp_exc);
        end
        tests++;
        if (in_ready !== !busy || dreq_valid !== busy ||
            (busy && (dreq_addr !== r_addr || dreq_strobe !== r_strb || dreq_data !== r_data))) begin
          fails++; $display("FAIL rand_bus@%0d: got rdy=%b v=%b a=%h s=%b d=%h want rdy=%b v=%b a=%h s=%b d=%h",
                            cyc, in_ready, dreq_valid, dreq_addr, dreq_strobe, dreq_data,
                            !busy, busy, r_addr, r_strb, r_data);
        end
      end
      exp_v = 0;
      case ($urandom_range(0, 3))
        0: op = F6_LW;
        1: op = F6_SW;
        default: op = 6'($urandom);
      endcase
      res = $urandom;
      if ($urandom_range(0, 2) != 0) res[1:0] = 2'b00;
      drive_instr(op, res, $urandom, 5'($urandom), 1'($urandom));
      in_valid = ($urandom_range(0, 2) != 0);
      dresp_data = $urandom;
      if (!busy) begin
        dresp_data_ok = ($urandom_range(0, 3) == 0);
        if (in_valid) begin
          if (op != F6_LW && op != F6_SW) begin
            exp_v = 1; exp_data = res; exp_dst = in_dst; exp_wen = in_wen; exp_exc = 0;
          end else if (res % 4 != 0) begin
            exp_v = 1; exp_data = res; exp_dst = in_dst; exp_wen = 0; exp_exc = 1;
          end else begin
            busy = 1;
            r_addr = res;
            r_load = (op == F6_LW);
            r_data = r_load ? 32'd0 : in_store_data;
            r_strb = r_load ? 4'b0000 : 4'b1111;
            r_dst = in_dst;
            r_wen = in_wen;
            wait_left = $urandom_range(0, 3);
          end
        end
      end else if (wait_left == 0) begin
        dresp_data_ok = 1'b1;
        exp_v = 1;
        exp_data = r_load ? dresp_data : 32'd0;
        exp_dst = r_dst;
        exp_wen = r_load ? r_wen : 1'b0;
        exp_exc = 0;
        busy = 0;
      end else begin
        dresp_data_ok = 1'b0;
        wait_left--;
      end
    end
    @(negedge clk);
    idle_inputs();
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_passthrough();
    test_load();
    test_store();
    test_misaligned();
    test_reset_mid_wait();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
